// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, with borrow out bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB-first over WIDTH clocks,
// presenting diff/bout with a one-cycle done pulse.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             fs_d;
  logic             fs_bo;

  full_subtractor u_fs (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (br),
    .d  (fs_d),
    .bo (fs_bo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          res  <= {fs_d, res[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= fs_bo;
          cnt  <= cnt + 1'b1;
          // Final bit: publish the assembled result directly so diff updates on this edge.
          if (cnt == LAST) begin
            diff  <= {fs_d, res[WIDTH-1:1]};
            bout  <= fs_bo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus queues expected results,
// a negedge monitor checks each done pulse for value and timing.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic prev_done = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (prev_done) check("done_single_cycle", 1, 0);
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("diff", int'(diff), int'(e.d));
        check("bout", int'(bout), int'(e.bo));
        check("done_cycle", cyc, e.cyc);
      end
    end
    prev_done = done;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; pulses start for one edge and returns at the next negedge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                       input bit push, input logic [W-1:0] ed, input logic eb);
    exp_t e;
    a = av; b = bv; bin = bi; start = 1'b1;
    if (push) begin
      e.d = ed; e.bo = eb; e.cyc = cyc + 1 + W;
      q.push_back(e);
    end
    step(1);
    start = 1'b0;
  endtask

  initial begin
    int nbusy;
    exp_t e;
    step(2);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_bout", int'(bout), 0);

    // Start accepted on the first edge with rst_n high.
    rst_n = 1'b1;
    issue(4'd5, 4'd3, 1'b0, 1'b1, 4'd2, 1'b0);
    nbusy = 0;
    for (int i = 0; i < 7; i++) begin
      if (busy) nbusy++;
      step(1);
    end
    check("busy_cycles", nbusy, W);

    issue(4'd3, 4'd5, 1'b0, 1'b1, 4'd14, 1'b1);  step(W + 1);
    issue(4'd0, 4'd0, 1'b1, 1'b1, 4'd15, 1'b1);  step(W + 1);
    issue(4'd15, 4'd15, 1'b0, 1'b1, 4'd0, 1'b0); step(W + 1);

    // Second start arrives while busy and must be ignored.
    issue(4'd9, 4'd2, 1'b0, 1'b1, 4'd7, 1'b0);
    step(1);
    a = 4'd1; b = 4'd1; start = 1'b1;
    step(1);
    start = 1'b0;
    step(W + 2);

    // Start held through DONE: back-to-back results 8-1 then 4-4.
    a = 4'd8; b = 4'd1; bin = 1'b0; start = 1'b1;
    e.d = 4'd7; e.bo = 1'b0; e.cyc = cyc + 1 + W;
    q.push_back(e);
    e.d = 4'd0; e.bo = 1'b0; e.cyc = cyc + 2 + 2 * W;
    q.push_back(e);
    step(1);
    a = 4'd4; b = 4'd4;
    step(W + 1);
    start = 1'b0;
    step(W + 3);

    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++) begin
          int r;
          r = ai - bi - ci;
          issue(W'(ai), W'(bi), ci[0], 1'b1, W'((r + 16) % 16), (r < 0));
          step(W + 1);
        end

    // Reset mid-operation abandons it; last result (15,15,1) was non-zero.
    issue(4'd7, 4'd2, 1'b0, 1'b0, '0, 1'b0);
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_diff", int'(diff), 0);
    check("midrst_bout", int'(bout), 0);
    issue(4'd6, 4'd1, 1'b0, 1'b1, 4'd5, 1'b0);
    step(W + 4);

    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
